// File: rtl/pic_icsp_loader_pkg.sv
// Shared ICSP constants: command codes, frame lengths and FSM state encodings.
package pic_icsp_loader_pkg;

  // Serial framing
  localparam int ICSP_CMD_LEN   = 6;   // command bits, LSB first
  localparam int ICSP_FRAME_LEN = 14;  // start bit + 12 data bits + stop bit

  // Programmer command codes
  localparam logic [ICSP_CMD_LEN-1:0] CMD_LOAD_DATA  = 6'h02;
  localparam logic [ICSP_CMD_LEN-1:0] CMD_READ_DATA  = 6'h04;
  localparam logic [ICSP_CMD_LEN-1:0] CMD_INC_ADDR   = 6'h06;
  localparam logic [ICSP_CMD_LEN-1:0] CMD_BEGIN_PROG = 6'h08;
  localparam logic [ICSP_CMD_LEN-1:0] CMD_RESET_ADDR = 6'h16;

  // Loader states
  typedef enum logic [2:0] {
    ICSP_IDLE     = 3'd0,
    ICSP_CMD      = 3'd1,
    ICSP_LOAD     = 3'd2,
    ICSP_RD_FETCH = 3'd3,
    ICSP_READ     = 3'd4,
    ICSP_PROG     = 3'd5
  } icsp_state_t;

endpackage

// File: rtl/pic_icsp_loader_sync_edge.sv
// Two-flop synchronizer for a slow asynchronous clock-like input, with
// single-cycle rise and fall pulses on the synchronized level.
module icsp_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/pic_icsp_loader.sv
// ICSP responder: decodes serial programmer commands and drives the
// PIC16C55 program memory write/read interface while holding the core.
module pic_icsp_loader
  import pic_icsp_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int INST_WIDTH  = 12,
  parameter int PROG_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_en,
  input  logic                  icsp_clk,
  input  logic                  icsp_din,
  output logic                  icsp_dout,
  output logic                  icsp_doe,
  output logic                  core_hold,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_WIDTH-1:0] mem_wdata,
  input  logic [INST_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam int PCW = $clog2(PROG_CYCLES + 1);

  // Synchronized serial clock edges
  logic sclk_rise;
  logic sclk_fall;

  icsp_sync_edge u_sclk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (icsp_clk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // Plain synchronizers for data-in and the programming-mode request
  logic din_meta_q, din_sync_q;
  logic pen_meta_q, pen_sync_q, pen_prev_q;
  logic pen_rise;

  // Two-flop synchronizers; prog_en keeps one extra flop for its rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_meta_q <= 1'b0;
      din_sync_q <= 1'b0;
      pen_meta_q <= 1'b0;
      pen_sync_q <= 1'b0;
      pen_prev_q <= 1'b0;
    end else begin
      din_meta_q <= icsp_din;
      din_sync_q <= din_meta_q;
      pen_meta_q <= prog_en;
      pen_sync_q <= pen_meta_q;
      pen_prev_q <= pen_sync_q;
    end
  end

  assign pen_rise = pen_sync_q & ~pen_prev_q;

  // Loader state
  icsp_state_t                 state_q, state_d;
  logic [2:0]                  cmd_cnt_q, cmd_cnt_d;
  logic [ICSP_CMD_LEN-2:0]     cmd_sr_q, cmd_sr_d;     // first five command bits
  logic [3:0]                  bit_cnt_q, bit_cnt_d;
  logic [INST_WIDTH-1:0]       data_sr_q, data_sr_d;   // data bits of a LOAD frame
  logic [ICSP_FRAME_LEN-1:0]   out_sr_q, out_sr_d;
  logic [PCW-1:0]              prog_cnt_q, prog_cnt_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [INST_WIDTH-1:0]       wdata_q, wdata_d;
  logic                        we_q, we_d;
  logic                        busy_q, busy_d;
  logic                        err_q, err_d;
  logic                        hold_q, hold_d;
  logic                        dout_q, dout_d;
  logic                        doe_q, doe_d;
  logic [ICSP_CMD_LEN-1:0]     cmd_word;

  // The sixth command bit completes the word straight from the synchronizer
  assign cmd_word = {din_sync_q, cmd_sr_q};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ICSP_IDLE;
      cmd_cnt_q  <= '0;
      cmd_sr_q   <= '0;
      bit_cnt_q  <= '0;
      data_sr_q  <= '0;
      out_sr_q   <= '0;
      prog_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
      dout_q     <= 1'b0;
      doe_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_cnt_q  <= cmd_cnt_d;
      cmd_sr_q   <= cmd_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      data_sr_q  <= data_sr_d;
      out_sr_q   <= out_sr_d;
      prog_cnt_q <= prog_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
    end
  end

  // Next-state logic: prog_en low overrides everything, including serial edges
  always_comb begin
    state_d    = state_q;
    cmd_cnt_d  = cmd_cnt_q;
    cmd_sr_d   = cmd_sr_q;
    bit_cnt_d  = bit_cnt_q;
    data_sr_d  = data_sr_q;
    out_sr_d   = out_sr_q;
    prog_cnt_d = prog_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    hold_d     = hold_q;
    dout_d     = dout_q;
    doe_d      = doe_q;

    if (!pen_sync_q) begin
      state_d    = ICSP_IDLE;
      hold_d     = 1'b0;
      busy_d     = 1'b0;
      doe_d      = 1'b0;
      dout_d     = 1'b0;
      cmd_cnt_d  = '0;
      bit_cnt_d  = '0;
      prog_cnt_d = '0;
    end else if (pen_rise) begin
      state_d   = ICSP_CMD;
      hold_d    = 1'b1;
      addr_d    = '0;
      err_d     = 1'b0;
      cmd_cnt_d = '0;
    end else begin
      case (state_q)
        ICSP_IDLE: begin
          state_d = ICSP_IDLE;
        end

        ICSP_CMD: begin
          if (sclk_rise) begin
            if (cmd_cnt_q == 3'(ICSP_CMD_LEN - 1)) begin
              cmd_cnt_d = '0;
              case (cmd_word)
                CMD_LOAD_DATA: begin
                  state_d   = ICSP_LOAD;
                  bit_cnt_d = '0;
                end
                CMD_READ_DATA: begin
                  state_d = ICSP_RD_FETCH;
                end
                CMD_INC_ADDR: begin
                  addr_d = addr_q + ADDR_WIDTH'(1);
                end
                CMD_BEGIN_PROG: begin
                  we_d       = 1'b1;
                  busy_d     = 1'b1;
                  prog_cnt_d = '0;
                  state_d    = ICSP_PROG;
                end
                CMD_RESET_ADDR: begin
                  addr_d = '0;
                end
                default: begin
                  err_d = 1'b1;
                end
              endcase
            end else begin
              cmd_sr_d  = {din_sync_q, cmd_sr_q[ICSP_CMD_LEN-2:1]};
              cmd_cnt_d = cmd_cnt_q + 3'd1;
            end
          end
        end

        ICSP_LOAD: begin
          if (sclk_rise) begin
            // Start (bit 0) and stop (last bit) are discarded
            if (bit_cnt_q == 4'(ICSP_FRAME_LEN - 1)) begin
              wdata_d   = data_sr_q;
              bit_cnt_d = '0;
              state_d   = ICSP_CMD;
            end else begin
              if (bit_cnt_q != 4'd0) begin
                data_sr_d = {din_sync_q, data_sr_q[INST_WIDTH-1:1]};
              end
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ICSP_RD_FETCH: begin
          // Address has been stable for a cycle, so mem_rdata is valid now
          out_sr_d  = {1'b0, mem_rdata, 1'b0};
          doe_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = ICSP_READ;
        end

        ICSP_READ: begin
          if (sclk_rise && (bit_cnt_q != 4'(ICSP_FRAME_LEN))) begin
            dout_d    = out_sr_q[0];
            out_sr_d  = {1'b0, out_sr_q[ICSP_FRAME_LEN-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (sclk_fall && (bit_cnt_q == 4'(ICSP_FRAME_LEN))) begin
            doe_d     = 1'b0;
            dout_d    = 1'b0;
            bit_cnt_d = '0;
            state_d   = ICSP_CMD;
          end
        end

        ICSP_PROG: begin
          // Serial edges are deliberately not looked at while programming
          if (prog_cnt_q == PCW'(PROG_CYCLES - 1)) begin
            busy_d     = 1'b0;
            prog_cnt_d = '0;
            state_d    = ICSP_CMD;
          end else begin
            prog_cnt_d = prog_cnt_q + PCW'(1);
          end
        end

        default: begin
          state_d = ICSP_IDLE;
        end
      endcase
    end
  end

  assign icsp_dout = dout_q;
  assign icsp_doe  = doe_q;
  assign core_hold = hold_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_pic_icsp_loader.sv
// Self-checking bench for pic_icsp_loader: directed scenarios plus a
// randomized command stream checked against a command-level model.
module tb_pic_icsp_loader;
  import pic_icsp_loader_pkg::*;

  localparam int AW = 9;
  localparam int IW = 12;
  localparam int PC = 16;
  localparam int H  = 4;    // serial clock half period in clk cycles
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_en;
  logic          icsp_clk;
  logic          icsp_din;
  logic          icsp_dout;
  logic          icsp_doe;
  logic          core_hold;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  logic [IW-1:0] mem_rdata;
  logic          busy;
  logic          cmd_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pic_icsp_loader #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .PROG_CYCLES(PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_en   (prog_en),
    .icsp_clk  (icsp_clk),
    .icsp_din  (icsp_din),
    .icsp_dout (icsp_dout),
    .icsp_doe  (icsp_doe),
    .core_hold (core_hold),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  // Program memory seen by the DUT, plus write/busy observers
  logic [IW-1:0] dev_mem [DEPTH];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [IW-1:0] pre_data = '0;
  int            we_cnt = 0;
  int            busy_cnt = 0;
  logic [AW-1:0] we_addr = '0;
  logic [IW-1:0] we_data = '0;

  always @(posedge clk) begin
    mem_rdata <= dev_mem[mem_addr];
    if (pre_we) dev_mem[pre_addr] <= pre_data;
    else if (mem_we) dev_mem[mem_addr] <= mem_wdata;
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Command-level reference model
  int            model_addr = 0;
  logic [IW-1:0] model_wdata = '0;
  logic          model_err = 1'b0;
  logic [IW-1:0] model_mem [DEPTH];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input int a, input logic [IW-1:0] d);
    pre_addr = AW'(a);
    pre_data = d;
    pre_we   = 1'b1;
    tick(1);
    pre_we   = 1'b0;
    model_mem[a] = d;
  endtask

  // One programmer bit: data set up, clock high, sample dout before the fall
  task automatic ser_bit(input logic b, output logic d, output logic oe);
    icsp_din = b;
    tick(2);
    icsp_clk = 1'b1;
    tick(H);
    d  = icsp_dout;
    oe = icsp_doe;
    icsp_clk = 1'b0;
    tick(H);
  endtask

  task automatic send_bits(input logic [13:0] v, input int n);
    logic d, oe;
    for (int i = 0; i < n; i++) ser_bit(v[i], d, oe);
  endtask

  task automatic send_cmd(input logic [5:0] c);
    send_bits({8'h00, c}, 6);
  endtask

  task automatic enter_prog();
    prog_en = 1'b0;
    tick(5);
    prog_en = 1'b1;
    tick(6);
    model_addr = 0;
    model_err  = 1'b0;
  endtask

  task automatic op_load(input logic [IW-1:0] d);
    logic st, sp;
    st = 1'($urandom);
    sp = 1'($urandom);
    send_cmd(CMD_LOAD_DATA);
    send_bits({sp, d, st}, 14);
    model_wdata = d;
  endtask

  task automatic op_inc();
    send_cmd(CMD_INC_ADDR);
    model_addr = (model_addr + 1) % DEPTH;
  endtask

  task automatic op_reset_addr();
    send_cmd(CMD_RESET_ADDR);
    model_addr = 0;
  endtask

  task automatic op_read(output logic [13:0] stream, output int oe_cnt);
    logic d, oe;
    send_cmd(CMD_READ_DATA);
    oe_cnt = 0;
    stream = '0;
    for (int i = 0; i < 14; i++) begin
      ser_bit(1'($urandom), d, oe);
      stream[i] = d;
      if (oe === 1'b1) oe_cnt++;
    end
  endtask

  task automatic wait_not_busy();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 200) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic test_reset();
    // Idle-under-reset values
    n_checks++;
    if ({core_hold, mem_we, busy, cmd_err, icsp_doe, icsp_dout, mem_addr, mem_wdata} !== '0) begin
      n_errors++;
      $display("FAIL reset_init: outputs=%h required 0",
               {core_hold, mem_we, busy, cmd_err, icsp_doe, icsp_dout, mem_addr, mem_wdata});
    end
    rst = 1'b1;
    tick(3);
    enter_prog();
    op_inc();
    op_load(12'h5A3);
    send_cmd(CMD_LOAD_DATA);
    send_bits(14'h3FFF, 5);
    rst = 1'b0;
    tick(1);
    n_checks++;
    if ({core_hold, mem_we, busy, cmd_err, icsp_doe, icsp_dout, mem_addr, mem_wdata} !== '0) begin
      n_errors++;
      $display("FAIL reset_midframe: outputs=%h required 0",
               {core_hold, mem_we, busy, cmd_err, icsp_doe, icsp_dout, mem_addr, mem_wdata});
    end
    model_wdata = '0;
    prog_en = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
    n_checks++;
    if (core_hold !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle_hold: core_hold=%b required 0", core_hold);
    end
    enter_prog();
    n_checks++;
    if (core_hold !== 1'b1 || mem_addr !== '0) begin
      n_errors++;
      $display("FAIL reset_enter: core_hold=%b addr=%0d required 1/0", core_hold, mem_addr);
    end
    $display("txn reset: done");
  endtask

  task automatic test_write();
    int we0, b0;
    op_load(12'hA5C);
    n_checks++;
    if (mem_wdata !== 12'hA5C) begin
      n_errors++;
      $display("FAIL write_latch: wdata=%h required a5c", mem_wdata);
    end
    we0 = we_cnt;
    b0  = busy_cnt;
    send_cmd(CMD_BEGIN_PROG);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL write_busy_high: busy=%b required 1", busy);
    end
    // Stray serial clock during programming must not be shifted in
    icsp_din = 1'b1;
    icsp_clk = 1'b1;
    tick(2);
    icsp_clk = 1'b0;
    tick(1);
    wait_not_busy();
    tick(2);
    n_checks++;
    if (we_cnt - we0 !== 1 || we_addr !== '0 || we_data !== 12'hA5C) begin
      n_errors++;
      $display("FAIL write_strobe: pulses=%0d addr=%0d data=%h required 1/0/a5c",
               we_cnt - we0, we_addr, we_data);
    end
    n_checks++;
    if (busy_cnt - b0 !== PC) begin
      n_errors++;
      $display("FAIL write_busy_len: busy cycles=%0d required %0d", busy_cnt - b0, PC);
    end
    model_mem[model_addr] = 12'hA5C;
    n_checks++;
    if (mem_addr !== AW'(model_addr)) begin
      n_errors++;
      $display("FAIL write_addr_hold: addr=%0d required %0d", mem_addr, model_addr);
    end
    op_inc();
    n_checks++;
    if (mem_addr !== AW'(model_addr) || cmd_err !== 1'b0) begin
      n_errors++;
      $display("FAIL write_next_cmd: addr=%0d err=%b required %0d/0", mem_addr, cmd_err, model_addr);
    end
    $display("txn write: addr=0 data=a5c");
  endtask

  task automatic test_readback();
    logic [13:0] s;
    int oe_cnt;
    enter_prog();
    preload(3, 12'h3F1);
    for (int i = 0; i < 3; i++) op_inc();
    n_checks++;
    if (mem_addr !== AW'(3)) begin
      n_errors++;
      $display("FAIL read_addr: addr=%0d required 3", mem_addr);
    end
    op_read(s, oe_cnt);
    n_checks++;
    if (s !== {1'b0, 12'h3F1, 1'b0}) begin
      n_errors++;
      $display("FAIL read_stream: got %h required %h", s, {1'b0, 12'h3F1, 1'b0});
    end
    n_checks++;
    if (oe_cnt !== 14 || icsp_doe !== 1'b0) begin
      n_errors++;
      $display("FAIL read_doe: doe bits=%0d doe_after=%b required 14/0", oe_cnt, icsp_doe);
    end
    $display("txn read: addr=3 stream=%h", s);
  endtask

  task automatic test_wrap();
    enter_prog();
    for (int i = 0; i < DEPTH - 1; i++) op_inc();
    n_checks++;
    if (mem_addr !== AW'(DEPTH - 1)) begin
      n_errors++;
      $display("FAIL wrap_top: addr=%0d required %0d", mem_addr, DEPTH - 1);
    end
    op_inc();
    n_checks++;
    if (mem_addr !== '0) begin
      n_errors++;
      $display("FAIL wrap_zero: addr=%0d required 0", mem_addr);
    end
    for (int i = 0; i < 100; i++) op_inc();
    n_checks++;
    if (mem_addr !== AW'(100)) begin
      n_errors++;
      $display("FAIL wrap_100: addr=%0d required 100", mem_addr);
    end
    op_reset_addr();
    n_checks++;
    if (mem_addr !== '0) begin
      n_errors++;
      $display("FAIL reset_addr: addr=%0d required 0", mem_addr);
    end
    $display("txn wrap: done");
  endtask

  task automatic test_bad_cmd();
    logic [IW-1:0] d;
    send_cmd(6'h3F);
    model_err = 1'b1;
    n_checks++;
    if (cmd_err !== 1'b1 || core_hold !== 1'b1) begin
      n_errors++;
      $display("FAIL bad_cmd_flag: err=%b hold=%b required 1/1", cmd_err, core_hold);
    end
    d = IW'($urandom);
    op_load(d);
    n_checks++;
    if (mem_wdata !== d || cmd_err !== 1'b1) begin
      n_errors++;
      $display("FAIL bad_cmd_recover: wdata=%h err=%b required %h/1", mem_wdata, cmd_err, d);
    end
    enter_prog();
    n_checks++;
    if (cmd_err !== 1'b0) begin
      n_errors++;
      $display("FAIL bad_cmd_clear: err=%b required 0", cmd_err);
    end
    $display("txn bad_cmd: 3f");
  endtask

  task automatic test_abort();
    logic [IW-1:0] d1, d2;
    d1 = IW'($urandom);
    d2 = ~d1;
    op_load(d1);
    send_cmd(CMD_LOAD_DATA);
    send_bits({1'b1, d2, 1'b0}, 7);
    prog_en = 1'b0;
    tick(5);
    n_checks++;
    if (mem_wdata !== d1 || core_hold !== 1'b0 || busy !== 1'b0 || icsp_doe !== 1'b0) begin
      n_errors++;
      $display("FAIL abort: wdata=%h hold=%b busy=%b doe=%b required %h/0/0/0",
               mem_wdata, core_hold, busy, icsp_doe, d1);
    end
    enter_prog();
    op_load(d2);
    n_checks++;
    if (mem_wdata !== d2) begin
      n_errors++;
      $display("FAIL abort_resume: wdata=%h required %h", mem_wdata, d2);
    end
    $display("txn abort: kept=%h", d1);
  endtask

  task automatic test_random();
    logic [13:0]  s;
    logic [5:0]   c;
    logic [IW-1:0] d;
    int oe_cnt, sel, we0, b0;
    enter_prog();
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: begin
          d = IW'($urandom);
          op_load(d);
          $display("txn rnd load: data=%h", d);
        end
        1: begin
          op_inc();
          $display("txn rnd inc: addr=%0d", model_addr);
        end
        2: begin
          op_reset_addr();
          $display("txn rnd reset_addr");
        end
        3: begin
          op_read(s, oe_cnt);
          n_checks++;
          if (s !== {1'b0, model_mem[model_addr], 1'b0} || oe_cnt !== 14) begin
            n_errors++;
            $display("FAIL rnd_read: stream=%h doe_bits=%0d required %h/14",
                     s, oe_cnt, {1'b0, model_mem[model_addr], 1'b0});
          end
          $display("txn rnd read: addr=%0d stream=%h", model_addr, s);
        end
        4: begin
          we0 = we_cnt;
          b0  = busy_cnt;
          send_cmd(CMD_BEGIN_PROG);
          wait_not_busy();
          tick(1);
          model_mem[model_addr] = model_wdata;
          n_checks++;
          if (we_cnt - we0 !== 1 || we_addr !== AW'(model_addr) || we_data !== model_wdata
              || busy_cnt - b0 !== PC) begin
            n_errors++;
            $display("FAIL rnd_prog: pulses=%0d addr=%0d data=%h busy=%0d required 1/%0d/%h/%0d",
                     we_cnt - we0, we_addr, we_data, busy_cnt - b0, model_addr, model_wdata, PC);
          end
          $display("txn rnd prog: addr=%0d data=%h", model_addr, model_wdata);
        end
        5: begin
          do c = 6'($urandom);
          while (c == CMD_LOAD_DATA || c == CMD_READ_DATA || c == CMD_INC_ADDR ||
                 c == CMD_BEGIN_PROG || c == CMD_RESET_ADDR);
          send_cmd(c);
          model_err = 1'b1;
          $display("txn rnd bad: cmd=%h", c);
        end
        default: begin
          enter_prog();
          $display("txn rnd prog_en toggle");
        end
      endcase
      n_checks++;
      if (mem_addr !== AW'(model_addr) || mem_wdata !== model_wdata || cmd_err !== model_err
          || core_hold !== 1'b1) begin
        n_errors++;
        $display("FAIL rnd_state: addr=%0d wdata=%h err=%b hold=%b required %0d/%h/%b/1",
                 mem_addr, mem_wdata, cmd_err, core_hold, model_addr, model_wdata, model_err);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    prog_en  = 1'b0;
    icsp_clk = 1'b0;
    icsp_din = 1'b0;
    tick(2);
    for (int i = 0; i < DEPTH; i++) preload(i, IW'($urandom));
    test_reset();
    test_write();
    test_readback();
    test_wrap();
    test_bad_cmd();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
